// File: rtl/regfile_write_port_if.sv
// Write-back request channel into the register file write port.
interface regfile_write_port_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_port.sv
// Write side of the 32x32 register file: in-order write buffer, one commit per
// cycle, falling-edge state updates, flat register bus and pending-write mask.
module regfile_write_port #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    regfile_write_port_if.slave        wr,
    input  logic                       wr_hold,
    output logic [1023:0]              regs_flat,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH):0]     buf_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   regs   [32];
    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          commit, push;

    assign commit       = !wr_hold && (count != '0);
    assign wr.wr_ready  = (count < CW'(DEPTH)) || commit;
    // Address 0 completes the handshake but never enters the buffer.
    assign push         = wr.wr_valid && wr.wr_ready && (wr.wr_addr != 5'd0);
    assign buf_count    = count;

    always_ff @(negedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (commit) begin
                regs[addr_q[rd_ptr]] <= data_q[rd_ptr];
                vld[rd_ptr]          <= 1'b0;
                rd_ptr               <= rd_ptr + PW'(1);
            end
            // Placed after the commit so a full buffer reusing the freed slot keeps it valid.
            if (push) begin
                addr_q[wr_ptr] <= wr.wr_addr;
                data_q[wr_ptr] <= wr.wr_data;
                vld[wr_ptr]    <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(commit);
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (vld[i]) pend_mask[addr_q[i]] = 1'b1;
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < 32; i++)
            regs_flat[32*i +: 32] = regs[i];
    end
endmodule

// File: tb/tb_regfile_write_port.sv
// Directed self-checking bench for regfile_write_port (DEPTH=2).
module tb_regfile_write_port;
    logic          clk = 1'b1;
    logic          reset;
    logic          wr_hold;
    logic [1023:0] regs_flat;
    logic [31:0]   pend_mask;
    logic [1:0]    buf_count;
    logic [1023:0] exp_flat;
    int checks = 0;
    int errors = 0;

    regfile_write_port_if wr ();

    regfile_write_port #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr.slave),
        .wr_hold   (wr_hold),
        .regs_flat (regs_flat),
        .pend_mask (pend_mask),
        .buf_count (buf_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        wr.wr_valid = v;
        wr.wr_addr  = a;
        wr.wr_data  = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_hold = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        tick(); tick();
        reset = 1'b1;
        #1;
        exp_flat = '0;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL reset_regs: got %h expected 0", regs_flat); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h expected 0", pend_mask); end
        checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", buf_count); end
        checks++; if (wr.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wr.wr_ready); end
    endtask

    task automatic test_single_write();
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL single_pend: got %h expected 00000020", pend_mask); end
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL single_early: got %h expected %h", regs_flat, exp_flat); end
        tick();
        exp_flat[191:160] = 32'hDEADBEEF;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL single_regs: got %h expected %h", regs_flat, exp_flat); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL single_pend_clr: got %h expected 0", pend_mask); end
    endtask

    task automatic test_reg0();
        drive(1'b1, 5'd0, 32'hFFFFFFFF);
        checks++; if (wr.wr_ready !== 1'b1) begin errors++; $display("FAIL reg0_ready: got %b expected 1", wr.wr_ready); end
        tick();
        drive(1'b0, 5'd0, 32'd0);
        checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL reg0_count: got %0d expected 0", buf_count); end
        checks++; if (pend_mask[0] !== 1'b0) begin errors++; $display("FAIL reg0_pend: got %b expected 0", pend_mask[0]); end
        tick();
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL reg0_regs: got %h expected %h", regs_flat, exp_flat); end
    endtask

    task automatic test_hold_full();
        wr_hold = 1'b1;
        drive(1'b1, 5'd1, 32'd1); tick();
        drive(1'b1, 5'd2, 32'd2); tick();
        drive(1'b1, 5'd3, 32'd3);
        checks++; if (buf_count !== 2'd2) begin errors++; $display("FAIL hold_count: got %0d expected 2", buf_count); end
        checks++; if (wr.wr_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b expected 0", wr.wr_ready); end
        checks++; if (pend_mask !== 32'h6) begin errors++; $display("FAIL hold_pend: got %h expected 00000006", pend_mask); end
        tick();
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL hold_nocommit: got %h expected %h", regs_flat, exp_flat); end
        wr_hold = 1'b0;
        #1;
        checks++; if (wr.wr_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", wr.wr_ready); end
        tick();
        drive(1'b0, 5'd0, 32'd0);
        exp_flat[63:32] = 32'd1;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL release_first: got %h expected %h", regs_flat, exp_flat); end
        checks++; if (pend_mask !== 32'hC) begin errors++; $display("FAIL release_pend: got %h expected 0000000c", pend_mask); end
        tick();
        exp_flat[95:64] = 32'd2;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL release_second: got %h expected %h", regs_flat, exp_flat); end
        tick();
        exp_flat[127:96] = 32'd3;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL release_third: got %h expected %h", regs_flat, exp_flat); end
        checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL release_count: got %0d expected 0", buf_count); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd7, 32'h11); tick();
        drive(1'b1, 5'd7, 32'h22); tick();
        drive(1'b0, 5'd0, 32'd0);
        checks++; if (pend_mask[7] !== 1'b1) begin errors++; $display("FAIL b2b_pend: got %b expected 1", pend_mask[7]); end
        checks++; if (regs_flat[255:224] !== 32'h11) begin errors++; $display("FAIL b2b_first: got %h expected 00000011", regs_flat[255:224]); end
        tick();
        exp_flat[255:224] = 32'h22;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL b2b_final: got %h expected %h", regs_flat, exp_flat); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL b2b_pend_clr: got %h expected 0", pend_mask); end
    endtask

    task automatic test_full_simul();
        wr_hold = 1'b1;
        drive(1'b1, 5'd10, 32'h10); tick();
        drive(1'b1, 5'd11, 32'h1011); tick();
        wr_hold = 1'b0;
        drive(1'b1, 5'd9, 32'hA5A5A5A5);
        checks++; if (wr.wr_ready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %b expected 1", wr.wr_ready); end
        tick();
        drive(1'b0, 5'd0, 32'd0);
        exp_flat[351:320] = 32'h10;
        checks++; if (buf_count !== 2'd2) begin errors++; $display("FAIL simul_count: got %0d expected 2", buf_count); end
        checks++; if (pend_mask !== 32'hA00) begin errors++; $display("FAIL simul_pend: got %h expected 00000a00", pend_mask); end
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL simul_c1: got %h expected %h", regs_flat, exp_flat); end
        tick();
        exp_flat[383:352] = 32'h1011;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL simul_c2: got %h expected %h", regs_flat, exp_flat); end
        tick();
        exp_flat[319:288] = 32'hA5A5A5A5;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL simul_c3: got %h expected %h", regs_flat, exp_flat); end
    endtask

    task automatic test_reset_mid();
        wr_hold = 1'b1;
        drive(1'b1, 5'd4, 32'h44); tick();
        drive(1'b1, 5'd6, 32'h66); tick();
        drive(1'b0, 5'd0, 32'd0);
        checks++; if (pend_mask !== 32'h50) begin errors++; $display("FAIL mid_pend_pre: got %h expected 00000050", pend_mask); end
        wr_hold = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        exp_flat = '0;
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL mid_regs: got %h expected 0", regs_flat); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL mid_pend: got %h expected 0", pend_mask); end
        checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", buf_count); end
        tick(); tick();
        checks++; if (regs_flat !== exp_flat) begin errors++; $display("FAIL mid_dropped: got %h expected 0", regs_flat); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_reg0();
        test_hold_full();
        test_back_to_back();
        test_full_simul();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
